// File: rtl/riscv_isa_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_isa_pkg                                                              |
// | RV32 B-type encoding constants, field struct and helper functions.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package riscv_isa_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int B_IMM_MIN = -4096;
    localparam int B_IMM_MAX = 4094;

    // Bit positions inside the 3-bit error vector {func3, align, range}.
    localparam int ERR_RANGE = 0;
    localparam int ERR_ALIGN = 1;
    localparam int ERR_FUNC3 = 2;

    typedef struct packed {
        logic [2:0]  func3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm13;
    } b_fields_t;

    function automatic logic b_func3_legal(input logic [2:0] f3);
        return (f3 == F3_BEQ)  || (f3 == F3_BNE)  ||
               (f3 == F3_BLT)  || (f3 == F3_BGE)  ||
               (f3 == F3_BLTU) || (f3 == F3_BGEU);
    endfunction

endpackage : riscv_isa_pkg
`default_nettype wire

// File: rtl/b_type_pack.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | b_type_pack                                                                |
// | Combinational packer: B-type fields -> 32-bit RV32 instruction word.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module b_type_pack
    import riscv_isa_pkg::*;
(
    input  b_fields_t   fields,
    output logic [31:0] instr
);

    // imm13[0] is implicitly zero in the B-type encoding and never stored.
    logic w_unused_imm_lsb;
    assign w_unused_imm_lsb = fields.imm13[0];

    assign instr = {fields.imm13[12],
                    fields.imm13[10:5],
                    fields.rs2,
                    fields.rs1,
                    fields.func3,
                    fields.imm13[4:1],
                    fields.imm13[11],
                    OPC_BRANCH};

endmodule : b_type_pack
`default_nettype wire

// File: rtl/b_type_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | b_type_encoder                                                             |
// | Two-stage valid/ready RV32 B-type assembler with legality checks and a    |
// | saturating error counter. Build option: B_ENC_RVC_ALIGN_EN (2-byte align). |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module b_type_encoder
    import riscv_isa_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_func3,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [2:0]       out_err,
    output logic [CNT_W-1:0] err_count
);

    logic             w_s1_adv;
    logic             w_s2_adv;

    logic [XLEN-1:0]  w_off;
    logic [XLEN-13:0] w_off_hi;
    logic             w_err_range;
    logic             w_err_align;
    logic             w_err_func3;
    logic [2:0]       w_err;
    b_fields_t        w_s1_next;

    logic             r_s1_valid;
    b_fields_t        r_s1_fields;
    logic [2:0]       r_s1_err;

    logic [31:0]      w_s1_instr;

    logic             r_s2_valid;
    logic [31:0]      r_s2_instr;
    logic [2:0]       r_s2_err;
    logic [CNT_W-1:0] r_err_count;

    // Stage 2 drains on consumer accept; stage 1 drains into a freed stage 2.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    // Offset legality: the 13-bit signed immediate must sign-extend to XLEN.
    assign w_off       = in_target - in_pc;
    assign w_off_hi    = w_off[XLEN-1:12];
    assign w_err_range = !((&w_off_hi) || !(|w_off_hi));
`ifdef B_ENC_RVC_ALIGN_EN
    assign w_err_align = w_off[0];
`else
    assign w_err_align = w_off[0] | w_off[1];
`endif
    assign w_err_func3 = !b_func3_legal(in_func3);

    always_comb begin
        w_err              = 3'b000;
        w_err[ERR_RANGE]   = w_err_range;
        w_err[ERR_ALIGN]   = w_err_align;
        w_err[ERR_FUNC3]   = w_err_func3;

        w_s1_next.func3    = in_func3;
        w_s1_next.rs1      = in_rs1;
        w_s1_next.rs2      = in_rs2;
        // A flagged word carries a zero immediate so it can never branch anywhere.
        w_s1_next.imm13    = (|w_err) ? 13'd0 : w_off[12:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_fields <= '0;
            r_s1_err    <= 3'b000;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_fields <= w_s1_next;
                r_s1_err    <= w_err;
            end
        end
    end

    b_type_pack u_pack (
        .fields (r_s1_fields),
        .instr  (w_s1_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_instr <= 32'd0;
            r_s2_err   <= 3'b000;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_instr <= w_s1_instr;
                r_s2_err   <= r_s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (r_s2_valid && out_ready && (|r_s2_err) && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_instr = r_s2_instr;
    assign out_err   = r_s2_err;
    assign err_count = r_err_count;

endmodule : b_type_encoder
`default_nettype wire

// File: tb/tb_b_type_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_b_type_encoder                                                          |
// | Scoreboard bench for b_type_encoder: directed vectors, stall, reset.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_b_type_encoder;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_func3 = 3'd0;
    logic [4:0]       in_rs1 = 5'd0;
    logic [4:0]       in_rs2 = 5'd0;
    logic [XLEN-1:0]  in_pc = '0;
    logic [XLEN-1:0]  in_target = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_instr;
    logic [2:0]       out_err;
    logic [CNT_W-1:0] err_count;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   exp_errs = 0;

    always #5 clk = ~clk;

    b_type_encoder #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_func3  (in_func3),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_pc     (in_pc),
        .in_target (in_target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    // Independent reference assembler.
    function automatic exp_t model(input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                                   input logic [31:0] pc, input logic [31:0] tgt);
        exp_t        e;
        logic [31:0] off;
        logic [19:0] hi;
        logic [12:0] imm;
        logic        rng, aln, f3e;
        off = tgt - pc;
        hi  = off[31:12];
        rng = !(hi == 20'h00000 || hi == 20'hFFFFF);
`ifdef B_ENC_RVC_ALIGN_EN
        aln = off[0];
`else
        aln = off[0] | off[1];
`endif
        f3e = (f3 == 3'b010) || (f3 == 3'b011);
        e.err = {f3e, aln, rng};
        imm = (e.err != 3'b000) ? 13'd0 : off[12:0];
        e.instr = {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'h63};
        return e;
    endfunction

    // Scoreboard: a handshake seen at this negedge completes at the next posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_word: got instr=%08h err=%03b with empty scoreboard", out_instr, out_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                total++;
                if (out_instr !== e.instr) begin
                    bad++;
                    $display("FAIL sb_instr: got %08h expected %08h", out_instr, e.instr);
                end
                total++;
                if (out_err !== e.err) begin
                    bad++;
                    $display("FAIL sb_err: got %03b expected %03b (instr %08h)", out_err, e.err, e.instr);
                end
                if (e.err != 3'b000) exp_errs++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] pc, input logic [31:0] tgt);
        in_valid  = 1'b1;
        in_func3  = f3;
        in_rs1    = r1;
        in_rs2    = r2;
        in_pc     = pc;
        in_target = tgt;
    endtask

    task automatic send(input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] pc, input logic [31:0] tgt, input exp_t e);
        logic acc;
        drive(f3, r1, r2, pc, tgt);
        sb.push_back(e);
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready=%0b never accepted request", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
        tick();
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #7;
        total++;
        if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_err !== 3'b000 || err_count !== '0) begin
            bad++;
            $display("FAIL reset_values: valid=%0b instr=%08h err=%03b cnt=%0d required 0/0/0/0",
                     out_valid, out_instr, out_err, err_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        logic seen;
        out_ready = 1'b1;
        send(3'b000, 5'd1, 5'd2, 32'h1000, 32'h1010, '{instr: 32'h00208863, err: 3'b000});
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL basic_latency: out_valid=%0b within 2 edges of accept, required 1", seen);
        end
        drain();
    endtask

    task automatic test_backward();
        send(3'b001, 5'd0, 5'd0, 32'h2000, 32'h1000, '{instr: 32'h80001063, err: 3'b000});
        drain();
    endtask

    task automatic test_errors();
        send(3'b000, 5'd3, 5'd4, 32'h0100, 32'h1100, '{instr: 32'h00418063, err: 3'b001});
        send(3'b010, 5'd5, 5'd6, 32'h0040, 32'h0048, '{instr: 32'h0062A063, err: 3'b100});
        drain();
        total++;
        if (err_count !== 16'd2) begin
            bad++;
            $display("FAIL err_count_two: got %0d required 2", err_count);
        end
    endtask

    task automatic test_align();
        exp_t e;
`ifdef B_ENC_RVC_ALIGN_EN
        e = '{instr: 32'h00000363, err: 3'b000};
`else
        e = '{instr: 32'h00000063, err: 3'b010};
`endif
        send(3'b000, 5'd0, 5'd0, 32'h0, 32'h6, e);
        drain();
        total++;
        if (err_count !== exp_errs[CNT_W-1:0]) begin
            bad++;
            $display("FAIL align_count: got %0d required %0d", err_count, exp_errs);
        end
    endtask

    task automatic test_back_to_back();
        time t0;
        out_ready = 1'b1;
        t0 = $time;
        for (int i = 0; i < 12; i++) begin
            logic [2:0]  f3;
            logic [4:0]  r1, r2;
            logic [31:0] pc, tgt;
            int          off;
            f3  = 3'($urandom_range(0, 7));
            r1  = 5'($urandom_range(0, 31));
            r2  = 5'($urandom_range(0, 31));
            pc  = $urandom & 32'hFFFF_FFFC;
            off = int'($urandom_range(0, 9000)) - 4500;
            tgt = pc + 32'(off);
            send(f3, r1, r2, pc, tgt, model(f3, r1, r2, pc, tgt));
        end
        total++;
        if ($time - t0 != 120) begin
            bad++;
            $display("FAIL b2b_throughput: 12 accepts took %0t, required 120", $time - t0);
        end
        drain();
    endtask

    task automatic bp_drive(input int i);
        case (i)
            0:       drive(3'b000, 5'd1, 5'd2, 32'h0000, 32'h0020);
            1:       drive(3'b001, 5'd3, 5'd4, 32'h0100, 32'h00FC);
            default: drive(3'b100, 5'd7, 5'd8, 32'h0000, 32'h0800);
        endcase
        sb.push_back(model(in_func3, in_rs1, in_rs2, in_pc, in_target));
    endtask

    task automatic test_backpressure();
        int    idx;
        logic  acc;
        exp_t  first;
        out_ready = 1'b0;
        idx = 0;
        bp_drive(0);
        first = sb[sb.size() - 1];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 3) bp_drive(idx); else in_valid = 1'b0;
            end
        end
        total++;
        if (idx != 2 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_accepts: accepted %0d in_ready=%0b, required 2/0", idx, in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_instr !== first.instr || out_err !== first.err) begin
                bad++;
                $display("FAIL bp_hold: valid=%0b instr=%08h err=%03b required 1/%08h/%03b",
                         out_valid, out_instr, out_err, first.instr, first.err);
            end
        end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_consecutive: out_valid=%0b at release cycle %0d, required 1", out_valid, c);
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx >= 3) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        total++;
        if (idx != 3) begin
            bad++;
            $display("FAIL bp_third_accept: accepted %0d required 3", idx);
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        send(3'b000, 5'd9, 5'd10, 32'h0, 32'h3, model(3'b000, 5'd9, 5'd10, 32'h0, 32'h3));
        send(3'b101, 5'd11, 5'd12, 32'h0, 32'h40, model(3'b101, 5'd11, 5'd12, 32'h0, 32'h40));
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_prefill: out_valid=%0b in_ready=%0b required 1/0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || err_count !== '0) begin
            bad++;
            $display("FAIL mid_async_reset: out_valid=%0b err_count=%0d required 0/0", out_valid, err_count);
        end
        sb.delete();
        exp_errs = 0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_stale: out_valid=%0b instr=%08h after reset, required 0", out_valid, out_instr);
            end
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backward();
        test_errors();
        test_align();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_b_type_encoder
`default_nettype wire
